// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - debounced push-button capture of an 8-bit switch byte with valid/ack handshake
// Optional macro SWITCH_READER_OVERRUN_EN adds a sticky OVERRUN flag; otherwise OVERRUN is tied low.
module switch_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW7,
  input  logic       SW6,
  input  logic       SW5,
  input  logic       SW4,
  input  logic       SW3,
  input  logic       SW2,
  input  logic       SW1,
  input  logic       SW0,
  input  logic       BTN,
  input  logic       ACK,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic [7:0] PRESS_COUNT,
  output logic       OVERRUN
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  logic [7:0]       sw_s1, sw_s2;
  logic             btn_s1, btn_s2;
  state_t           state;
  logic [CNT_W-1:0] count;
  logic             cap;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1  <= 8'h00;
      sw_s2  <= 8'h00;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0};
      sw_s2  <= sw_s1;
      btn_s1 <= BTN;
      btn_s2 <= btn_s1;
    end
  end

  // cap is a registered one-cycle pulse; the output stage acts on it the following edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RELEASED;
      count <= '0;
      cap   <= 1'b0;
    end else begin
      cap <= 1'b0;
      case (state)
        RELEASED: begin
          if (btn_s2) begin
            state <= PRESS_CHK;
            count <= ONE;
          end
        end
        PRESS_CHK: begin
          if (!btn_s2) begin
            state <= RELEASED;
            count <= '0;
          end else if (count == LAST) begin
            state <= PRESSED;
            count <= '0;
            cap   <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        PRESSED: begin
          if (!btn_s2) begin
            state <= RELEASE_CHK;
            count <= ONE;
          end
        end
        RELEASE_CHK: begin
          if (btn_s2) begin
            state <= PRESSED;
            count <= '0;
          end else if (count == LAST) begin
            state <= RELEASED;
            count <= '0;
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          state <= RELEASED;
          count <= '0;
        end
      endcase
    end
  end

  // A capture takes priority over a same-edge acknowledge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA        <= 8'h00;
      VALID       <= 1'b0;
      PRESS_COUNT <= 8'h00;
    end else if (cap) begin
      DATA        <= sw_s2;
      VALID       <= 1'b1;
      PRESS_COUNT <= PRESS_COUNT + 8'd1;
    end else if (VALID && ACK) begin
      VALID <= 1'b0;
    end
  end

`ifdef SWITCH_READER_OVERRUN_EN
  logic ovr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovr <= 1'b0;
    end else if (cap) begin
      if (VALID) ovr <= !ACK;
    end else if (VALID && ACK) begin
      ovr <= 1'b0;
    end
  end

  assign OVERRUN = ovr;
`else
  assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_switch_reader.sv
// tb/tb_switch_reader.sv - scoreboard bench for switch_reader with a window-based debounce reference model
module tb_switch_reader;

  localparam int DC = 4;

  logic       CLK, RST, BTN, ACK;
  logic [7:0] sw;
  logic [7:0] DATA, PRESS_COUNT;
  logic       VALID, OVERRUN;

  switch_reader #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .SW7(sw[7]), .SW6(sw[6]), .SW5(sw[5]), .SW4(sw[4]),
    .SW3(sw[3]), .SW2(sw[2]), .SW1(sw[1]), .SW0(sw[0]),
    .BTN(BTN), .ACK(ACK),
    .DATA(DATA), .VALID(VALID), .PRESS_COUNT(PRESS_COUNT), .OVERRUN(OVERRUN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {int e; logic [7:0] d; logic [7:0] c; logic o;} cap_t;
  typedef struct {int e; logic [7:0] d;} ack_t;

  cap_t cap_q[$];
  ack_t ack_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;

  // Reference model: the debounced level flips once the last DC synchronized samples
  // all disagree with it; the resulting capture is visible one edge later.
  logic       bh[$];
  logic [7:0] swh[$];
  logic       syn[$];
  logic       m_deb, m_pend, m_valid, m_ov;
  logic [7:0] m_data, m_cnt;

  `ifdef SWITCH_READER_OVERRUN_EN
  localparam logic OV_EXP = 1'b1;
  `else
  localparam logic OV_EXP = 1'b0;
  `endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    bh.delete(); swh.delete(); syn.delete();
    m_deb = 0; m_pend = 0; m_valid = 0; m_ov = 0; m_data = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic cyc(input logic b, input logic [7:0] s, input logic a);
    logic       fin, all_diff;
    logic [7:0] sws;
    BTN = b; sw = s; ACK = a;
    @(posedge CLK);
    edge_n++;
    bh.push_back(b); swh.push_back(s);
    if (bh.size() > 8) begin void'(bh.pop_front()); void'(swh.pop_front()); end
    fin = (bh.size() >= 3) ? bh[bh.size()-3] : 1'b0;
    sws = (swh.size() >= 3) ? swh[swh.size()-3] : 8'h00;
    if (m_pend) begin
      if (m_valid) m_ov = OV_EXP & !a;
      m_data = sws; m_valid = 1'b1; m_cnt = m_cnt + 8'd1;
      cap_q.push_back('{edge_n, m_data, m_cnt, m_ov});
    end else if (m_valid && a) begin
      m_valid = 1'b0; m_ov = 1'b0;
      ack_q.push_back('{edge_n, m_data});
    end
    m_pend = 1'b0;
    syn.push_back(fin);
    if (syn.size() > DC) void'(syn.pop_front());
    if (syn.size() == DC) begin
      all_diff = 1'b1;
      foreach (syn[i]) if (syn[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_deb = !m_deb;
        if (m_deb) m_pend = 1'b1;
      end
    end
    #1;
  endtask

  task automatic press(input logic [7:0] s, input int hi, input int lo);
    repeat (hi) cyc(1'b1, s, 1'b0);
    repeat (lo) cyc(1'b0, s, 1'b0);
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    #1;
    chk("rst_async_outputs", {DATA, VALID, PRESS_COUNT, OVERRUN}, 32'h0);
    model_reset();
    @(posedge CLK);
    edge_n++;
    #1;
    RST = 1'b0;
  endtask

  // Monitor: a PRESS_COUNT change marks a capture, a VALID fall marks an acknowledge
  logic [7:0] pc = 8'h00;
  logic       pv = 1'b0;
  initial begin
    cap_t ce;
    ack_t ae;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (PRESS_COUNT != pc) begin
          if (cap_q.size() == 0) chk("cap_unexpected", {24'h0, PRESS_COUNT}, {24'h0, pc});
          else begin
            ce = cap_q.pop_front();
            chk("cap_edge", edge_n, ce.e);
            chk("cap_data", {24'h0, DATA}, {24'h0, ce.d});
            chk("cap_count", {24'h0, PRESS_COUNT}, {24'h0, ce.c});
            chk("cap_valid", {31'h0, VALID}, 32'h1);
            chk("cap_overrun", {31'h0, OVERRUN}, {31'h0, ce.o});
          end
        end else if (pv && !VALID) begin
          if (ack_q.size() == 0) chk("ack_unexpected", {31'h0, VALID}, 32'h1);
          else begin
            ae = ack_q.pop_front();
            chk("ack_edge", edge_n, ae.e);
            chk("ack_data_hold", {24'h0, DATA}, {24'h0, ae.d});
            chk("ack_overrun_clr", {31'h0, OVERRUN}, 32'h0);
          end
        end
      end
      pc = PRESS_COUNT;
      pv = VALID;
    end
  end

  initial begin
    logic       b;
    logic [7:0] s;
    RST = 1'b0; BTN = 1'b0; ACK = 1'b0; sw = 8'h00;
    model_reset();
    #1 RST = 1'b1;
    #1 chk("reset_state", {DATA, VALID, PRESS_COUNT, OVERRUN}, 32'h0);
    repeat (2) begin @(posedge CLK); edge_n++; end
    #1 RST = 1'b0;

    // short glitch
    press(8'hFF, 2, 10);
    chk("glitch_valid", {31'h0, VALID}, 32'h0);
    chk("glitch_count_data", {16'h0, PRESS_COUNT, DATA}, 32'h0);

    // first press, latency
    repeat (6) cyc(1'b1, 8'hA5, 1'b0);
    chk("lat_not_early", {31'h0, VALID}, 32'h0);
    cyc(1'b1, 8'hA5, 1'b0);
    chk("p1_valid", {31'h0, VALID}, 32'h1);
    chk("p1_data", {24'h0, DATA}, 32'hA5);
    chk("p1_count", {24'h0, PRESS_COUNT}, 32'h1);
    repeat (8) cyc(1'b0, 8'hA5, 1'b0);

    // acknowledge, then second press
    cyc(1'b0, 8'hA5, 1'b1);
    chk("ack_valid", {31'h0, VALID}, 32'h0);
    chk("ack_data", {24'h0, DATA}, 32'hA5);
    press(8'h3C, 7, 8);
    chk("p2_data", {24'h0, DATA}, 32'h3C);
    chk("p2_count", {24'h0, PRESS_COUNT}, 32'h2);

    // overrun
    cyc(1'b0, 8'h3C, 1'b1);
    press(8'h01, 7, 8);
    press(8'h02, 7, 8);
    chk("ovr_data", {24'h0, DATA}, 32'h02);
    chk("ovr_flag", {31'h0, OVERRUN}, {31'h0, OV_EXP});
    cyc(1'b0, 8'h02, 1'b1);
    chk("ovr_cleared", {30'h0, VALID, OVERRUN}, 32'h0);

    // capture on the same edge as acknowledge
    press(8'h11, 7, 8);
    repeat (6) cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h22, 1'b1);
    chk("capack_valid", {31'h0, VALID}, 32'h1);
    chk("capack_data", {24'h0, DATA}, 32'h22);
    chk("capack_ovr", {31'h0, OVERRUN}, 32'h0);
    repeat (8) cyc(1'b0, 8'h22, 1'b0);

    // 256 presses wrap, then a 1000-cycle hold
    rst_pulse();
    for (int i = 0; i < 256; i++) press(8'($urandom), 5, 6);
    chk("wrap_count", {24'h0, PRESS_COUNT}, 32'h0);
    repeat (1000) cyc(1'b1, 8'h5A, 1'b0);
    repeat (8) cyc(1'b0, 8'h5A, 1'b0);
    chk("hold_count", {24'h0, PRESS_COUNT}, 32'h1);

    // async reset mid press-check with VALID set, button still held afterwards
    press(8'h77, 7, 8);
    repeat (4) cyc(1'b1, 8'h99, 1'b0);
    rst_pulse();
    repeat (6) cyc(1'b1, 8'h99, 1'b0);
    chk("rst_lat_not_early", {31'h0, VALID}, 32'h0);
    cyc(1'b1, 8'h99, 1'b0);
    chk("rst_repress", {15'h0, VALID, PRESS_COUNT, DATA}, {15'h0, 1'b1, 8'h01, 8'h99});

    // randomized bounce/press/ack traffic
    b = 1'b1; s = 8'h99;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) b = !b;
      if ($urandom_range(0, 7) == 0) s = 8'($urandom);
      cyc(b, s, ($urandom_range(0, 4) == 0));
    end
    repeat (10) cyc(1'b0, s, 1'b0);
    cyc(1'b0, s, 1'b1);
    cyc(1'b0, s, 1'b0);
    @(negedge CLK);
    #1;
    chk("cap_q_drained", cap_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("final_count", {24'h0, PRESS_COUNT}, {24'h0, m_cnt});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
